uart_rx_core: RTL and testbench

//  UART receive engine; consumes rx_sample_pulse (16x bit rate) from the baud clock generator.

---
 rtl/uart_rx_core_pkg.sv | 22 ++
 rtl/uart_rx_core_sync.sv | 23 ++
 rtl/uart_rx_core.sv | 203 ++++++++++++++++++++
 tb/tb_uart_rx_core.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_core_pkg.sv
// Shared constants, FSM state type and vote helper for the UART receive engine.
package uart_rx_core_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic [3:0]  VOTE_FIRST = 4'd7;
  localparam logic [3:0]  VOTE_MID   = 4'd8;
  localparam logic [3:0]  VOTE_LAST  = 4'd9;
  localparam logic [3:0]  SAMP_LAST  = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } rx_state_e;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_core_sync.sv
// Multi-flop synchroniser for the asynchronous rxd line; resets to the idle (high) level.
module uart_rx_core_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain_q <= '1;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receive engine: start validation, 3-sample majority vote, 7/8-bit frames,
// optional parity, stop check and a single holding register with error flags.
module uart_rx_core
  import uart_rx_core_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       rx_sample_pulse,
  input  logic       rxd,
  input  logic       data_bits_8,
  input  logic       parity_en,
  input  logic       parity_odd,
  input  logic       rx_ack,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overrun_err,
  output logic       rx_busy
);

  logic rxd_s;

  uart_rx_core_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(PCLK),
    .rst(PRESET),
    .d  (rxd),
    .q  (rxd_s)
  );

  rx_state_e  state_q, state_d;
  logic [3:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] bit_idx_q, bit_idx_d;
  logic [7:0] shift_q, shift_d;
  logic [1:0] vote_q, vote_d;
  logic       par_bit_q, par_bit_d;
  logic       stop_bit_q, stop_bit_d;
  logic       cfg_8_q, cfg_8_d;
  logic       cfg_pen_q, cfg_pen_d;
  logic       cfg_odd_q, cfg_odd_d;
  logic       armed_q, armed_d;
  logic       done_q, done_d;

  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;
  logic       ovr_q, ovr_d;

  logic       vote;
  logic [2:0] last_idx;
  logic [7:0] frame_data;
  logic       frame_perr;

  assign vote       = majority3(vote_q[0], vote_q[1], rxd_s);
  assign last_idx   = cfg_8_q ? 3'd7 : 3'd6;
  // In 7-bit mode the first data bit lands in shift[1]; bit 7 of the result reads as 0.
  assign frame_data = cfg_8_q ? shift_q : {1'b0, shift_q[7:1]};
  assign frame_perr = cfg_pen_q & ((^frame_data) ^ par_bit_q ^ cfg_odd_q);

  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    vote_d     = vote_q;
    par_bit_d  = par_bit_q;
    stop_bit_d = stop_bit_q;
    cfg_8_d    = cfg_8_q;
    cfg_pen_d  = cfg_pen_q;
    cfg_odd_d  = cfg_odd_q;
    armed_d    = armed_q;
    done_d     = 1'b0;

    if (rx_sample_pulse) begin
      samp_cnt_d = samp_cnt_q + 4'd1;
      if (samp_cnt_q == VOTE_FIRST) vote_d[0] = rxd_s;
      if (samp_cnt_q == VOTE_MID)   vote_d[1] = rxd_s;

      unique case (state_q)
        StIdle: begin
          samp_cnt_d = 4'd0;
          // After a break the line must be seen high before another start is accepted.
          if (rxd_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            state_d   = StStart;
            cfg_8_d   = data_bits_8;
            cfg_pen_d = parity_en;
            cfg_odd_d = parity_odd;
          end
        end
        StStart: begin
          if (samp_cnt_q == VOTE_LAST && vote) begin
            state_d    = StIdle;
            samp_cnt_d = 4'd0;
          end else if (samp_cnt_q == SAMP_LAST) begin
            state_d   = StData;
            bit_idx_d = 3'd0;
          end
        end
        StData: begin
          if (samp_cnt_q == VOTE_LAST) shift_d = {vote, shift_q[7:1]};
          if (samp_cnt_q == SAMP_LAST) begin
            if (bit_idx_q == last_idx) begin
              state_d = cfg_pen_q ? StParity : StStop;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end
        end
        StParity: begin
          if (samp_cnt_q == VOTE_LAST) par_bit_d = vote;
          if (samp_cnt_q == SAMP_LAST) state_d = StStop;
        end
        StStop: begin
          // Finish mid stop bit so a following start edge is never missed.
          if (samp_cnt_q == VOTE_LAST) begin
            stop_bit_d = vote;
            armed_d    = vote;
            done_d     = 1'b1;
            state_d    = StIdle;
            samp_cnt_d = 4'd0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    if (done_q && (!valid_q || rx_ack)) begin
      data_d  = frame_data;
      perr_d  = frame_perr;
      ferr_d  = ~stop_bit_q;
      valid_d = 1'b1;
      if (valid_q) ovr_d = 1'b0;
    end else if (done_q) begin
      ovr_d = 1'b1;
    end else if (rx_ack && valid_q) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= StIdle;
      samp_cnt_q <= 4'd0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'd0;
      vote_q     <= 2'b11;
      par_bit_q  <= 1'b0;
      stop_bit_q <= 1'b1;
      cfg_8_q    <= 1'b1;
      cfg_pen_q  <= 1'b0;
      cfg_odd_q  <= 1'b0;
      armed_q    <= 1'b1;
      done_q     <= 1'b0;
      data_q     <= 8'd0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      vote_q     <= vote_d;
      par_bit_q  <= par_bit_d;
      stop_bit_q <= stop_bit_d;
      cfg_8_q    <= cfg_8_d;
      cfg_pen_q  <= cfg_pen_d;
      cfg_odd_q  <= cfg_odd_d;
      armed_q    <= armed_d;
      done_q     <= done_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      ovr_q      <= ovr_d;
    end
  end

  assign rx_data     = data_q;
  assign rx_valid    = valid_q;
  assign parity_err  = perr_q;
  assign framing_err = ferr_q;
  assign overrun_err = ovr_q;
  assign rx_busy     = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: serial frames driven at 16 PCLK per bit, results popped
// from an expectation queue by an independent monitor.
module tb_uart_rx_core;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       rx_sample_pulse = 1'b1;
  logic       rxd = 1'b1;
  logic       data_bits_8 = 1'b1;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       mon_ack = 1'b0;
  logic       stim_ack = 1'b0;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid, parity_err, framing_err, overrun_err, rx_busy;

  assign rx_ack = mon_ack | stim_ack;

  uart_rx_core #(
    .SYNC_STAGES(2)
  ) dut (
    .PCLK           (PCLK),
    .PRESET         (PRESET),
    .rx_sample_pulse(rx_sample_pulse),
    .rxd            (rxd),
    .data_bits_8    (data_bits_8),
    .parity_en      (parity_en),
    .parity_odd     (parity_odd),
    .rx_ack         (rx_ack),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .parity_err     (parity_err),
    .framing_err    (framing_err),
    .overrun_err    (overrun_err),
    .rx_busy        (rx_busy)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   loads = 0;
  bit   auto_ack = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  // Drives one frame; the ideal parity bit makes XOR(data, parity) equal parity_odd.
  task automatic send_frame(input logic [7:0] data, input bit b8, input bit pen, input bit odd,
                            input bit flip, input bit stopv, input bit ack_done, input bit push);
    logic [7:0] d;
    logic       pbit;
    int         nb;
    nb = b8 ? 8 : 7;
    d = data;
    if (!b8) d[7] = 1'b0;
    pbit = (^d) ^ odd ^ flip;
    data_bits_8 = b8;
    parity_en = pen;
    parity_odd = odd;
    if (push) exp_q.push_back('{d, pen && flip, !stopv});
    rxd = 1'b0;
    tick(16);
    for (int i = 0; i < nb; i++) begin
      rxd = d[i];
      tick(16);
    end
    if (pen) begin
      rxd = pbit;
      tick(16);
    end
    rxd = stopv;
    if (ack_done) begin
      // Completion lands 14 edges into the stop bit (sync delay + mid-bit vote + register).
      tick(13);
      stim_ack = 1'b1;
      tick(1);
      stim_ack = 1'b0;
      tick(2);
    end else begin
      tick(16);
    end
    rxd = 1'b1;
  endtask

  // Monitor: every new load of the holding register is compared with the oldest expectation.
  initial begin
    logic       pv;
    logic [7:0] pd;
    exp_t       e;
    pv = 1'b0;
    pd = 8'd0;
    forever begin
      @(negedge PCLK);
      if (!PRESET && rx_valid && (!pv || rx_data != pd)) begin
        loads++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_frame: got data 0x%0h, expected no frame", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", {24'd0, rx_data}, {24'd0, e.data});
          check("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
          check("framing_err", {31'd0, framing_err}, {31'd0, e.ferr});
        end
        if (auto_ack) begin
          mon_ack = 1'b1;
          @(negedge PCLK);
          mon_ack = 1'b0;
          check("ack_clears_valid", {31'd0, rx_valid}, 32'd0);
        end
      end
      pv = rx_valid;
      pd = rx_data;
    end
  end

  initial begin
    int t;
    int base;
    tick(4);
    check("reset_valid", {31'd0, rx_valid}, 32'd0);
    check("reset_data", {24'd0, rx_data}, 32'd0);
    check("reset_errs", {29'd0, parity_err, framing_err, overrun_err}, 32'd0);
    check("reset_busy", {31'd0, rx_busy}, 32'd0);
    PRESET = 1'b0;
    tick(20);

    send_frame(8'hA5, 1, 0, 0, 0, 1, 0, 1);
    tick(20);
    send_frame(8'h41, 0, 1, 1, 0, 1, 0, 1);
    tick(20);
    send_frame(8'h41, 0, 1, 1, 1, 1, 0, 1);
    tick(20);
    send_frame(8'h3C, 1, 0, 0, 0, 0, 0, 1);
    tick(20);

    // Break: a single all-zero frame with framing error, no restart while the line stays low.
    data_bits_8 = 1'b1;
    parity_en = 1'b0;
    base = loads;
    exp_q.push_back('{8'h00, 1'b0, 1'b1});
    rxd = 1'b0;
    tick(200);
    rxd = 1'b1;
    tick(40);
    check("break_one_frame", loads - base, 32'd1);

    // Short low glitch is rejected by the start-bit vote.
    base = loads;
    rxd = 1'b0;
    tick(4);
    rxd = 1'b1;
    t = 0;
    while (!rx_busy && t < 10) begin
      tick(1);
      t++;
    end
    check("glitch_busy_rise", {31'd0, rx_busy}, 32'd1);
    while (rx_busy && t < 16) begin
      tick(1);
      t++;
    end
    check("glitch_busy_drop", {31'd0, rx_busy}, 32'd0);
    tick(20);
    check("glitch_no_frame", loads - base, 32'd0);

    // Overrun: second frame discarded while the first is unread.
    auto_ack = 1'b0;
    send_frame(8'h11, 1, 0, 0, 0, 1, 0, 1);
    send_frame(8'h22, 1, 0, 0, 0, 1, 0, 0);
    tick(4);
    check("overrun_set", {31'd0, overrun_err}, 32'd1);
    check("overrun_valid", {31'd0, rx_valid}, 32'd1);
    check("overrun_data_kept", {24'd0, rx_data}, 32'h11);
    stim_ack = 1'b1;
    tick(1);
    stim_ack = 1'b0;
    check("ack_clears_overrun", {31'd0, overrun_err}, 32'd0);
    check("ack_clears_valid2", {31'd0, rx_valid}, 32'd0);
    check("ack_data_holds", {24'd0, rx_data}, 32'h11);
    tick(10);

    // Ack on the completion cycle lets the new frame load without overrun.
    send_frame(8'h11, 1, 0, 0, 0, 1, 0, 1);
    send_frame(8'h22, 1, 0, 0, 0, 1, 1, 1);
    tick(4);
    check("ack_done_no_overrun", {31'd0, overrun_err}, 32'd0);
    check("ack_done_valid", {31'd0, rx_valid}, 32'd1);
    stim_ack = 1'b1;
    tick(1);
    stim_ack = 1'b0;
    auto_ack = 1'b1;
    tick(10);

    for (int n = 0; n < 24; n++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                 $urandom_range(0, 4) != 0, 0, 1);
      tick($urandom_range(4, 20));
    end

    // Reset in the middle of the data bits aborts the frame and clears the holding register.
    send_frame(8'hC3, 1, 0, 0, 0, 1, 0, 1);
    tick(20);
    data_bits_8 = 1'b1;
    parity_en = 1'b0;
    rxd = 1'b0;
    tick(16);
    rxd = 1'b1;
    tick(16);
    rxd = 1'b0;
    tick(8);
    check("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
    PRESET = 1'b1;
    rxd = 1'b1;
    tick(1);
    PRESET = 1'b0;
    check("midreset_busy", {31'd0, rx_busy}, 32'd0);
    check("midreset_data", {24'd0, rx_data}, 32'd0);
    check("midreset_valid", {31'd0, rx_valid}, 32'd0);
    tick(30);
    send_frame(8'h5A, 1, 0, 0, 0, 1, 0, 1);

    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      tick(1);
      t++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    tick(10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
